twofish_round_ctrl: RTL and testbench



---
 rtl/twofish_round_ctrl.sv | 108 ++++++++++
 tb/tb_twofish_round_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twofish_round_ctrl.sv
// Twofish encrypt sequencer: input whitening, ROUNDS passes through an external
// combinational round stage, then final-swap undo plus output whitening.
module twofish_round_ctrl #(
    parameter int ROUNDS = 16,
    parameter int RW     = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   pt,
    input  logic [255:0]   wkey,
    output logic [31:0]    st_r0,
    output logic [31:0]    st_r1,
    output logic [31:0]    st_r2,
    output logic [31:0]    st_r3,
    output logic [RW-1:0]  rnd_idx,
    input  logic [31:0]    nx_r0,
    input  logic [31:0]    nx_r1,
    input  logic [31:0]    nx_r2,
    input  logic [31:0]    nx_r3,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   ct
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    state_t              state_q, state_d;
    logic [3:0][31:0]    st_q, st_d;
    logic [3:0][31:0]    kout_q, kout_d;   // K4..K7, index 0 = K4
    logic [127:0]        ct_q, ct_d;
    logic [RW-1:0]       rnd_q, rnd_d;
    logic                out_valid_q, out_valid_d;
    logic [3:0][31:0]    nx;

    assign nx = {nx_r3, nx_r2, nx_r1, nx_r0};

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        kout_d      = kout_q;
        ct_d        = ct_q;
        rnd_d       = rnd_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < 4; i++)
                        st_d[i] = pt[32*i +: 32] ^ wkey[32*i +: 32];
                    kout_d  = wkey[255:128];
                    rnd_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d = nx;
                if (rnd_q == LAST) begin
                    // Round stage output is post-swap; pair words 2,3,0,1 with K4..K7.
                    ct_d = {nx[1] ^ kout_q[3], nx[0] ^ kout_q[2],
                            nx[3] ^ kout_q[1], nx[2] ^ kout_q[0]};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    rnd_d = rnd_q + RW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    rnd_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            kout_q      <= '0;
            ct_q        <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            kout_q      <= kout_d;
            ct_q        <= ct_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign ct        = ct_q;
    assign rnd_idx   = rnd_q;
    assign st_r0     = st_q[0];
    assign st_r1     = st_q[1];
    assign st_r2     = st_q[2];
    assign st_r3     = st_q[3];
endmodule

// File: tb/tb_twofish_round_ctrl.sv
// Scoreboard bench for twofish_round_ctrl with a selectable stub round stage.
module tb_twofish_round_ctrl;
    localparam int ROUNDS = 16;
    localparam int RW     = 4;
    typedef logic [3:0][31:0] w4_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          rdy_man = 1'b1;
    logic          rdy_rnd = 1'b1;
    bit            rand_rdy = 1'b0;
    logic          out_ready;
    logic [127:0]  pt = '0;
    logic [255:0]  wkey = '0;
    logic          in_ready, busy, out_valid;
    logic [31:0]   st_r0, st_r1, st_r2, st_r3;
    logic [31:0]   nx_r0, nx_r1, nx_r2, nx_r3;
    logic [RW-1:0] rnd_idx;
    logic [127:0]  ct;
    w4_t           nxw;

    int mode = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic ov_prev = 1'b0;
    logic [127:0] exp_q[$];

    twofish_round_ctrl #(.ROUNDS(ROUNDS), .RW(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pt(pt), .wkey(wkey), .st_r0(st_r0), .st_r1(st_r1), .st_r2(st_r2),
        .st_r3(st_r3), .rnd_idx(rnd_idx), .nx_r0(nx_r0), .nx_r1(nx_r1),
        .nx_r2(nx_r2), .nx_r3(nx_r3), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .ct(ct)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rdy_rnd <= 1'($urandom_range(0, 1));
    assign out_ready = rand_rdy ? rdy_rnd : rdy_man;

    // Stub round stage: 0 identity, 1 increment, 2 mixing function of round index.
    function automatic w4_t rf(input w4_t s, input int r, input int m);
        w4_t o;
        case (m)
            0: o = s;
            1: for (int i = 0; i < 4; i++) o[i] = s[i] + 32'd1;
            default: begin
                o[0] = s[2] ^ (s[0] * 32'h9E3779B9 + 32'(r));
                o[1] = s[3] ^ {s[1][23:0], s[1][31:24]};
                o[2] = s[0] + s[1];
                o[3] = s[1] ^ 32'hA5A5A5A5 ^ 32'(r);
            end
        endcase
        return o;
    endfunction

    always_comb nxw = rf({st_r3, st_r2, st_r1, st_r0}, int'(rnd_idx), mode);
    assign nx_r0 = nxw[0];
    assign nx_r1 = nxw[1];
    assign nx_r2 = nxw[2];
    assign nx_r3 = nxw[3];

    function automatic logic [127:0] ref_ct(input logic [127:0] p, input logic [255:0] k,
                                            input int m);
        w4_t w;
        for (int i = 0; i < 4; i++) w[i] = p[32*i +: 32] ^ k[32*i +: 32];
        for (int r = 0; r < ROUNDS; r++) w = rf(w, r, m);
        return {w[1] ^ k[255:224], w[0] ^ k[223:192], w[3] ^ k[191:160], w[2] ^ k[159:128]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && !ov_prev) chk("latency", 128'(cyc - acc_cyc), 128'(ROUNDS));
        ov_prev <= out_valid;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL ct_unexpected: got %h expected none", ct);
            end else begin
                chk("ct", ct, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [127:0] p, input logic [255:0] k, input int m,
                        input logic [127:0] e);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        mode = m;
        pt = p;
        wkey = k;
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        wkey = {rnd128(), rnd128()};
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !in_ready) && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || !in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ct"}, ct, 0);
        chk({tag, "_rnd_idx"}, rnd_idx, 0);
        chk({tag, "_st"}, {st_r3, st_r2, st_r1, st_r0}, 0);
    endtask

    initial begin
        logic [127:0] p0, wt, ct0, pr;
        logic [255:0] wk, kr;
        int t;
        p0 = 128'h00000003_00000002_00000001_00000000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Identity stub: checks round index stepping and the word reorder.
        send(p0, '0, 0, {32'h1, 32'h0, 32'h3, 32'h2});
        for (int j = 0; j < ROUNDS; j++) begin
            @(negedge clk);
            chk("rnd_step", rnd_idx, j);
        end
        @(negedge clk);
        chk("done_valid", out_valid, 1);
        chk("done_rnd", rnd_idx, ROUNDS - 1);
        drain();

        send(p0, '0, 1, {32'h11, 32'h10, 32'h13, 32'h12});
        drain();

        // Whitening: wkey is scrambled right after accept inside send.
        for (int j = 0; j < 8; j++) wk[32*j +: 32] = 32'h11111111 * (j + 1);
        send('0, wk, 0, {32'hAAAAAAAA, 32'h66666666, 32'h22222222, 32'h66666666});
        @(negedge clk);
        chk("whiten_st", {st_r3, st_r2, st_r1, st_r0},
            {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        drain();

        // Backpressure in DONE.
        rdy_man = 1'b0;
        pr = rnd128();
        kr = {rnd128(), rnd128()};
        send(pr, kr, 2, ref_ct(pr, kr, 2));
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reach_done", out_valid, 1);
        ct0 = ct;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            in_valid = 1'(j % 2);
            pt = rnd128();
            @(negedge clk);
            chk("bp_ct_hold", ct, ct0);
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_rnd_hold", rnd_idx, ROUNDS - 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rdy_man = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_busy", busy, 0);
        drain();

        // Abort at round 7.
        pr = rnd128();
        kr = {rnd128(), rnd128()};
        send(pr, kr, 2, ref_ct(pr, kr, 2));
        for (int j = 0; j < 8; j++) @(negedge clk);
        chk("abort_rnd", rnd_idx, 7);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk_reset_vals("abort");
        rst = 1'b0;
        pr = rnd128();
        kr = {rnd128(), rnd128()};
        send(pr, kr, 2, ref_ct(pr, kr, 2));
        drain();

        // Random blocks with random consumer readiness.
        rand_rdy = 1'b1;
        for (int n = 0; n < 25; n++) begin
            int m;
            m = int'($urandom_range(0, 2));
            pr = rnd128();
            kr = {rnd128(), rnd128()};
            send(pr, kr, m, ref_ct(pr, kr, m));
        end
        drain();
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
